// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH independent PWM channels behind one E100 command/response
// port. Each channel keeps shadow and active period/compare/enable/invert
// registers; new settings reach the active set only at the channel's period
// boundary, or on the next cycle if the channel is currently disabled.
//
// Optional feature: define PWM_CENTER_ALIGNED_EN for up/down (center-aligned)
// counting with updates applied at the valley. Without it the channels are
// edge-aligned and no direction register exists.
module pwm_multi #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 32,
    parameter int CH_BITS = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clock_valid,
    input  logic               pwm_command,
    output logic               pwm_response,
    input  logic [CH_BITS-1:0] pwm_channel,
    input  logic [WIDTH-1:0]   pwm_period,
    input  logic [WIDTH-1:0]   pwm_compare,
    input  logic               pwm_enable,
    input  logic               pwm_invert,
    output logic [NUM_CH-1:0]  pwm_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   write_cycle;

    // Handshake state register; frozen while clock_valid is low.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else if (clock_valid) begin
            state <= state_next;
        end
    end

    // Next-state decode: command starts a write, its release ends the response.
    // NOTE: the default assignment comes first so every path assigns
    // state_next and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (pwm_command) state_next = S_WRITE;
            S_WRITE: state_next = S_RESP;
            S_RESP:  if (!pwm_command) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Registered acknowledge: high exactly while the FSM sits in RESP.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_response <= 1'b0;
        end else if (clock_valid) begin
            pwm_response <= (state_next == S_RESP);
        end
    end

    assign write_cycle = (state == S_WRITE);

    // Channel indices at or above NUM_CH have no matching slice below, so a
    // write to them only completes the handshake.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_BITS-1:0] CH_IDX = CH_BITS'(i);

        logic [WIDTH-1:0] sh_period;
        logic [WIDTH-1:0] sh_compare;
        logic             sh_enable;
        logic             sh_invert;
        logic [WIDTH-1:0] act_period;
        logic [WIDTH-1:0] act_compare;
        logic             act_enable;
        logic             act_invert;
        logic             pending;
        logic [WIDTH-1:0] counter;
        logic             out_q;

        logic             write_hit;
        logic             load_new;
        logic             load_point;
        logic [WIDTH-1:0] new_period;
        logic [WIDTH-1:0] new_compare;
        logic             new_enable;
        logic             new_invert;
`ifdef PWM_CENTER_ALIGNED_EN
        logic             count_down;
        logic [WIDTH-1:0] eff_period;
`endif

        // Select what loads at a boundary: a coinciding write beats the shadow.
        always_comb begin
            write_hit   = write_cycle && (pwm_channel == CH_IDX);
            load_new    = write_hit || pending;
            new_period  = write_hit ? pwm_period  : sh_period;
            new_compare = write_hit ? pwm_compare : sh_compare;
            new_enable  = write_hit ? pwm_enable  : sh_enable;
            new_invert  = write_hit ? pwm_invert  : sh_invert;
`ifdef PWM_CENTER_ALIGNED_EN
            load_point  = count_down && (counter == '0);
            eff_period  = load_new ? new_period : act_period;
`else
            load_point  = (counter == act_period);
`endif
        end

        // Shadow capture, boundary transfer, counting and registered output.
        // NOTE: these are per-channel flops rather than a memory, so every one
        // of them is cleared by reset.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sh_period   <= '0;
                sh_compare  <= '0;
                sh_enable   <= 1'b0;
                sh_invert   <= 1'b0;
                act_period  <= '0;
                act_compare <= '0;
                act_enable  <= 1'b0;
                act_invert  <= 1'b0;
                pending     <= 1'b0;
                counter     <= '0;
                out_q       <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
                count_down  <= 1'b0;
`endif
            end else if (clock_valid) begin
                if (write_hit) begin
                    sh_period  <= pwm_period;
                    sh_compare <= pwm_compare;
                    sh_enable  <= pwm_enable;
                    sh_invert  <= pwm_invert;
                end

                // A disabled channel idles at its invert level.
                out_q <= (act_enable && (counter < act_compare)) ^ act_invert;

                if (!act_enable) begin
                    // Stopped: hold the counter and accept a pending update
                    // immediately, which is how a channel gets started.
                    counter <= '0;
`ifdef PWM_CENTER_ALIGNED_EN
                    count_down <= 1'b0;
`endif
                    if (pending) begin
                        act_period  <= sh_period;
                        act_compare <= sh_compare;
                        act_enable  <= sh_enable;
                        act_invert  <= sh_invert;
                    end
                    pending <= write_hit;
                end else if (load_point) begin
                    if (load_new) begin
                        act_period  <= new_period;
                        act_compare <= new_compare;
                        act_enable  <= new_enable;
                        act_invert  <= new_invert;
                    end
                    pending <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
                    // Valley: climb again, unless the period is zero.
                    if (eff_period == '0) begin
                        counter    <= '0;
                        count_down <= 1'b1;
                    end else begin
                        counter    <= WIDTH'(1);
                        count_down <= 1'b0;
                    end
`else
                    counter <= '0;
`endif
                end else begin
`ifdef PWM_CENTER_ALIGNED_EN
                    if (!count_down) begin
                        if (counter >= act_period) begin
                            count_down <= 1'b1;
                            counter    <= (counter == '0) ? '0 : counter - WIDTH'(1);
                        end else begin
                            counter <= counter + WIDTH'(1);
                        end
                    end else begin
                        counter <= counter - WIDTH'(1);
                    end
`else
                    counter <= counter + WIDTH'(1);
`endif
                    if (write_hit) begin
                        pending <= 1'b1;
                    end
                end
            end
        end

        assign pwm_out[i] = out_q;
    end

endmodule
